// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its requester agents.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  // Number of requesters the round-robin arbiter serves.
  localparam int NUM_CLIENTS = 4;

  // Requester agent FSM: idle, holding req until grant, playing the burst.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/arb_cmd_fifo.sv
// Register-based command FIFO; the head entry is read straight from storage.
// Latency: a push is visible at the head one edge later; a pop frees the slot one edge later.
// Backpressure: full blocks pushes (no push-through-pop); pops on an empty FIFO are ignored.
module arb_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_an,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_V);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Only a push with free space, and a pop with data present, take effect.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and clears storage.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : arb_cmd_fifo

// File: rtl/arb_req_agent.sv
// Requester agent: queues client bursts, holds req until grant, plays the burst on the bus.
// Latency: req rises two edges after a push into an empty FIFO; beat 0 appears right after the grant edge.
// Backpressure: cmd_ready = !full (no push-through-pop); the shared bus itself has no backpressure.
module arb_req_agent
  import arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              timeout_err,
  output logic              proto_err
);

  localparam int CMD_W  = LEN_W + DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  // One queued command, sized from this agent's widths.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } cmd_t;

  arb_state_e        state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, req_d;
  logic              timeout_err_q, timeout_err_d;
  logic              proto_err_q, proto_err_d;

  cmd_t              wr_cmd;
  cmd_t              head;
  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign wr_cmd    = '{len: cmd_len, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  arb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_an  (rst_an),
    .push    (fifo_push),
    .wr_data (wr_cmd),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // FSM next state, beat/wait counters, FIFO pop and sticky error flags.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    wait_d        = wait_q;
    fifo_pop      = 1'b0;
    timeout_err_d = timeout_err_q;
    proto_err_d   = proto_err_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end
      REQ: begin
        if (grant) begin
          state_d = XFER;
          beat_d  = '0;
        end else if (wait_q != TIMEOUT_V) begin
          wait_d = wait_q + 1'b1;
        end
      end
      XFER: begin
        if (beat_q == head.len) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Starvation is flagged on the edge the wait counter reaches its limit; req stays up.
    if (state_q == REQ && wait_d == TIMEOUT_V) begin
      timeout_err_d = 1'b1;
    end
    // A grant is only legal while we are requesting; elsewhere it is only recorded.
    if (grant && state_q != REQ) begin
      proto_err_d = 1'b1;
    end
    req_d = (state_d == REQ);
  end

  // State registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      wait_q        <= '0;
      req_q         <= 1'b0;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
      req_q         <= req_d;
      timeout_err_q <= timeout_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign req         = req_q;
  assign timeout_err = timeout_err_q;
  assign proto_err   = proto_err_q;
  assign bus_valid   = (state_q == XFER);
  assign bus_data    = bus_valid ? DATA_W'(head.data + DATA_W'(beat_q)) : '0;
  assign bus_last    = bus_valid && (beat_q == head.len);
  assign busy        = (fifo_count != '0) || (state_q != IDLE);

endmodule : arb_req_agent

// File: tb/tb_arb_req_agent.sv
// Bench for arb_req_agent: directed scenarios, a transaction-level reference model
// compared every cycle, and literal expectations on the collected bursts.
module tb_arb_req_agent;

  localparam int DATA_W     = 8;
  localparam int LEN_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;

  logic              clk = 1'b0;
  logic              rst_an = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              grant = 1'b0;
  logic              cmd_ready, req, bus_valid, bus_last, busy, timeout_err, proto_err;
  logic [DATA_W-1:0] bus_data;

  int errors = 0;
  int checks = 0;

  arb_req_agent #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_an(rst_an),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .req(req), .grant(grant),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A queue of pending commands; the agent is either idle, waiting for a grant
  // (m_req) for m_wait cycles, or playing beat m_beat of the queue head.
  typedef struct {
    int len;
    int data;
  } mcmd_t;

  mcmd_t mq[$];
  bit    m_req = 0;
  int    m_wait = 0;
  int    m_beat = -1;
  bit    m_tmo = 0;
  bit    m_proto = 0;

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      mq.delete();
      m_req = 0; m_wait = 0; m_beat = -1; m_tmo = 0; m_proto = 0;
    end else begin
      bit accept;
      accept = cmd_valid && (mq.size() < FIFO_DEPTH);
      if (m_beat >= 0) begin
        if (grant) m_proto = 1;
        if (m_beat == mq[0].len) begin
          void'(mq.pop_front());
          m_beat = -1;
        end else begin
          m_beat++;
        end
      end else if (m_req) begin
        if (grant) begin
          m_req  = 0;
          m_beat = 0;
        end else begin
          if (m_wait < TIMEOUT) m_wait++;
          if (m_wait == TIMEOUT) m_tmo = 1;
        end
      end else begin
        if (grant) m_proto = 1;
        if (mq.size() > 0) begin
          m_req  = 1;
          m_wait = 0;
        end
      end
      if (accept) mq.push_back('{len: int'(cmd_len), data: int'(cmd_data)});
    end
  end

  // Per-cycle comparison of every output against the model.
  logic       e_vld, e_last;
  logic [7:0] e_data;
  always @(negedge clk) begin
    e_vld  = (m_beat >= 0);
    e_data = e_vld ? 8'(mq[0].data + m_beat) : 8'h00;
    e_last = e_vld && (m_beat == mq[0].len);
    chk("cyc_req", req, m_req);
    chk("cyc_bus_valid", bus_valid, e_vld);
    chk("cyc_bus_data", bus_data, e_data);
    chk("cyc_bus_last", bus_last, e_last);
    chk("cyc_cmd_ready", cmd_ready, mq.size() < FIFO_DEPTH);
    chk("cyc_busy", busy, (mq.size() > 0) || m_req || e_vld);
    chk("cyc_timeout_err", timeout_err, m_tmo);
    chk("cyc_proto_err", proto_err, m_proto);
  end

  // Collect beats for the literal burst checks.
  logic [7:0] seen_d[$];
  logic       seen_l[$];
  always @(negedge clk) begin
    if (bus_valid) begin
      seen_d.push_back(bus_data);
      seen_l.push_back(bus_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic grant_pulse();
    grant = 1'b1;
    tick();
    grant = 1'b0;
  endtask

  task automatic wait_req(input string name, input int max);
    int n = 0;
    while (!req && n < max) begin
      tick();
      n++;
    end
    chk({name, "_req_seen"}, req, 1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  // Burst of n beats starting at 'first', wrapping in 8 bits, last flag on the final beat.
  task automatic chk_burst(input string name, input int at, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      if (at + k < seen_d.size()) begin
        chk({name, "_data"}, seen_d[at+k], 8'(first + k));
        chk({name, "_last"}, seen_l[at+k], (k == n - 1));
      end else begin
        chk({name, "_missing_beat"}, 0, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_an = 1'b0;
    tick(); tick();
    chk("rst_req", req, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus_valid", bus_valid, 0);
    rst_an = 1'b1;
    tick();

    // 1. Single command, grant three cycles after req rises
    seen_d.delete(); seen_l.delete();
    push(8'h10, 4'd2);
    chk("t1_req_not_yet", req, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_req_rise", req, 1);
    repeat (2) begin
      tick();
      chk("t1_req_hold", req, 1);
    end
    grant_pulse();
    chk("t1_req_drop", req, 0);
    chk("t1_beat0_valid", bus_valid, 1);
    wait_idle("t1", 20);
    chk("t1_nbeats", seen_d.size(), 3);
    if (seen_d.size() == 3) begin
      chk("t1_b0", seen_d[0], 8'h10);
      chk("t1_b2", seen_d[2], 8'h12);
      chk("t1_last2", seen_l[2], 1);
      chk("t1_last1", seen_l[1], 0);
    end

    // 2. Fill the FIFO, reject a fifth command, req gap between bursts
    seen_d.delete(); seen_l.delete();
    push(8'h20, 4'd0);
    push(8'h30, 4'd1);
    push(8'h40, 4'd0);
    push(8'h50, 4'd0);
    chk("t2_full_ready", cmd_ready, 0);
    push(8'h60, 4'd0);
    chk("t2_still_full", cmd_ready, 0);
    chk("t2_req_up", req, 1);
    grant_pulse();
    tick();
    chk("t2_ready_after_pop", cmd_ready, 1);
    chk("t2_req_gap", req, 0);
    for (int i = 0; i < 3; i++) begin
      wait_req("t2", 20);
      grant_pulse();
    end
    wait_idle("t2", 20);
    chk("t2_nbeats", seen_d.size(), 5);
    if (seen_d.size() == 5) begin
      chk("t2_b4", seen_d[4], 8'h50);
      chk("t2_b2", seen_d[2], 8'h31);
    end
    chk_burst("t2_burst0", 0, 8'h20, 1);
    chk_burst("t2_burst1", 1, 8'h30, 2);

    // 3. Payload wrap
    seen_d.delete(); seen_l.delete();
    push(8'hFE, 4'd3);
    wait_req("t3", 10);
    grant_pulse();
    wait_idle("t3", 20);
    chk("t3_nbeats", seen_d.size(), 4);
    if (seen_d.size() == 4) begin
      chk("t3_b1", seen_d[1], 8'hFF);
      chk("t3_b2", seen_d[2], 8'h00);
      chk("t3_b3", seen_d[3], 8'h01);
      chk("t3_last3", seen_l[3], 1);
    end
    chk_burst("t3_burst", 0, 8'hFE, 4);

    // 4. Starvation: timeout_err exactly 16 cycles after req rises
    seen_d.delete(); seen_l.delete();
    push(8'h70, 4'd1);
    wait_req("t4", 10);
    repeat (15) tick();
    chk("t4_tmo_at15", timeout_err, 0);
    tick();
    chk("t4_tmo_at16", timeout_err, 1);
    chk("t4_req_held", req, 1);
    repeat (3) tick();
    grant_pulse();
    wait_idle("t4", 20);
    chk_burst("t4_burst", 0, 8'h70, 2);
    chk("t4_tmo_sticky", timeout_err, 1);

    // 5. Spurious grants in IDLE and mid-XFER
    seen_d.delete(); seen_l.delete();
    chk("t5_proto_before", proto_err, 0);
    grant_pulse();
    chk("t5_proto_idle", proto_err, 1);
    chk("t5_busy_idle", busy, 0);
    push(8'h80, 4'd3);
    wait_req("t5", 10);
    grant_pulse();
    tick();
    grant_pulse();
    chk("t5_still_xfer", bus_valid, 1);
    wait_idle("t5", 20);
    chk("t5_nbeats", seen_d.size(), 4);
    chk_burst("t5_burst", 0, 8'h80, 4);
    chk("t5_proto_sticky", proto_err, 1);

    // 6. Reset on beat 1 of a len=5 burst with two commands queued behind it
    push(8'h90, 4'd5);
    push(8'hA0, 4'd1);
    push(8'hB0, 4'd2);
    wait_req("t6", 10);
    grant_pulse();
    tick();
    chk("t6_on_beat1", bus_data, 8'h91);
    #2 rst_an = 1'b0;
    #1;
    chk("t6_rst_bus_valid", bus_valid, 0);
    chk("t6_rst_req", req, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tmo", timeout_err, 0);
    chk("t6_rst_proto", proto_err, 0);
    tick(); tick();
    rst_an = 1'b1;
    seen_d.delete(); seen_l.delete();
    repeat (10) tick();
    chk("t6_no_beats", seen_d.size(), 0);
    chk("t6_idle_req", req, 0);
    chk("t6_idle_busy", busy, 0);
    push(8'hC0, 4'd0);
    wait_req("t6_new", 10);
    grant_pulse();
    wait_idle("t6_new", 10);
    chk_burst("t6_new_burst", 0, 8'hC0, 1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_arb_req_agent
